// File: rtl/frame_buffer_write_arbiter_if.sv
// frame_buffer_write_arbiter_if
//   Bundles the signals around the frame buffer write arbiter: the three
//   requester handshakes, the registered frame_buffer write port, and the
//   swap sequencing to and from graphics_fsm.
//   master : requester / graphics_fsm / frame_buffer side (drives requests and swap_req)
//   slave  : the arbiter itself
interface frame_buffer_write_arbiter_if #(
  parameter int ADDR_WIDTH = 19
);
  logic [2:0]              req_valid;
  logic [3*ADDR_WIDTH-1:0] req_addr;
  logic [2:0]              req_data;
  logic [2:0]              req_ready;
  logic                    write_enable;
  logic [ADDR_WIDTH-1:0]   write_addr;
  logic                    write_data;
  logic                    swap_req;
  logic                    swap;
  logic                    swap_ack;
  logic                    oob_error;

  modport master (
    output req_valid, req_addr, req_data, swap_req,
    input  req_ready, write_enable, write_addr, write_data, swap, swap_ack, oob_error
  );

  modport slave (
    input  req_valid, req_addr, req_data, swap_req,
    output req_ready, write_enable, write_addr, write_data, swap, swap_ack, oob_error
  );
endinterface

// File: rtl/frame_buffer_write_arbiter.sv
// frame_buffer_write_arbiter
//   Round-robin arbiter sharing the single frame_buffer write port among
//   fill (0), line (1) and symbol (2) drawers, plus the RUN/SWAP/ACK sequencer
//   that guarantees no write is presented on the cycle the buffers swap.
//   Ports:
//     clk, rst_n : clock (rising edge), asynchronous active-low reset
//     bus        : slave modport of frame_buffer_write_arbiter_if
//                  (req_valid/req_addr/req_data/req_ready, write_enable/
//                   write_addr/write_data, swap_req/swap/swap_ack, oob_error)

// Per-requester address range check.
module fbwa_lane #(
  parameter int ADDR_WIDTH   = 19,
  parameter int PIXELS_COUNT = 307200
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  in_range
);
  // Compare one bit wider so a power-of-two pixel count does not truncate to 0.
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(PIXELS_COUNT);
  assign in_range = {1'b0, addr} < LIMIT;
endmodule

module frame_buffer_write_arbiter #(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480
) (
  input  logic                         clk,
  input  logic                         rst_n,
  frame_buffer_write_arbiter_if.slave  bus
);
  localparam int PIXELS_COUNT = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
  localparam int ADDR_WIDTH   = $clog2(PIXELS_COUNT);
  localparam int NUM_REQ      = 3;

  typedef enum logic [1:0] {RUN, SWAP, ACK} state_t;

  state_t state, state_nxt;
  logic [1:0] rr_ptr;

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_REQ-1:0]                 in_range;
  logic [NUM_REQ-1:0]                 grant;
  logic [NUM_REQ-1:0]                 acc;
  logic [1:0]                         acc_idx;
  logic [1:0]                         idx;
  logic                               found;
  logic                               grant_en;

  assign addr_v = bus.req_addr;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_lane
      fbwa_lane #(.ADDR_WIDTH(ADDR_WIDTH), .PIXELS_COUNT(PIXELS_COUNT)) u_lane (
        .addr     (addr_v[g]),
        .in_range (in_range[g])
      );
    end
  endgenerate

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = 2'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Next state: swap_req is only honoured in RUN, never queued.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (bus.swap_req) state_nxt = SWAP;
      SWAP:    state_nxt = ACK;
      ACK:     state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Outputs. Grants are masked by rst_n so ready drops the moment reset asserts.
  always_comb begin
    grant_en      = (state == RUN) && !bus.swap_req && rst_n;
    bus.req_ready = grant_en ? grant : '0;
    bus.swap      = (state == SWAP);
    bus.swap_ack  = (state == ACK);
  end

  assign acc = bus.req_valid & bus.req_ready;

  always_comb begin
    acc_idx = 2'd0;
    for (int i = 0; i < NUM_REQ; i++)
      if (acc[i]) acc_idx = 2'(i);
  end

  // Write port register. Out-of-range requests are consumed but never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr           <= 2'd2;
      bus.write_enable <= 1'b0;
      bus.write_addr   <= '0;
      bus.write_data   <= 1'b0;
      bus.oob_error    <= 1'b0;
    end else if (|acc) begin
      rr_ptr <= acc_idx;
      if (in_range[acc_idx]) begin
        bus.write_enable <= 1'b1;
        bus.write_addr   <= addr_v[acc_idx];
        bus.write_data   <= bus.req_data[acc_idx];
      end else begin
        bus.write_enable <= 1'b0;
        bus.oob_error    <= 1'b1;
      end
    end else begin
      bus.write_enable <= 1'b0;
    end
  end
endmodule

// File: tb/tb_frame_buffer_write_arbiter.sv
module tb_frame_buffer_write_arbiter;
  localparam int AW = 19;

  logic clk = 1'b0;
  logic rst_n;

  frame_buffer_write_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  frame_buffer_write_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    valid;
    logic [AW-1:0] a0, a1, a2;
    logic [2:0]    data;
    logic          sreq;
    logic [2:0]    rdy;
    logic          we;
    logic [AW-1:0] wa;
    logic          wd;
    logic          sw, ak, oob;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic [2:0] v, input int a0, input int a1, input int a2,
                              input logic [2:0] d, input logic sr, input logic [2:0] rdy,
                              input logic we, input int wa, input logic wd,
                              input logic sw, input logic ak, input logic oob);
    vec_t r;
    r.valid = v; r.a0 = AW'(a0); r.a1 = AW'(a1); r.a2 = AW'(a2);
    r.data = d; r.sreq = sr; r.rdy = rdy; r.we = we; r.wa = AW'(wa);
    r.wd = wd; r.sw = sw; r.ak = ak; r.oob = oob;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input int a0, input int a1, input int a2,
                       input logic [2:0] d, input logic sr);
    bus.req_valid = v;
    bus.req_addr  = {AW'(a2), AW'(a1), AW'(a0)};
    bus.req_data  = d;
    bus.swap_req  = sr;
  endtask

  task automatic check_all(input string tag, input vec_t e);
    check({tag, ".ready"}, 32'(bus.req_ready),    32'(e.rdy));
    check({tag, ".we"},    32'(bus.write_enable), 32'(e.we));
    check({tag, ".waddr"}, 32'(bus.write_addr),   32'(e.wa));
    check({tag, ".wdata"}, 32'(bus.write_data),   32'(e.wd));
    check({tag, ".swap"},  32'(bus.swap),         32'(e.sw));
    check({tag, ".ack"},   32'(bus.swap_ack),     32'(e.ak));
    check({tag, ".oob"},   32'(bus.oob_error),    32'(e.oob));
  endtask

  initial begin
    vec_t e;
    // Round robin from reset, data bits fill=1 line=0 symbol=1
    tbl.push_back(mk(3'b111, 10, 20, 30, 3'b101, 0, 3'b001, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(3'b111, 10, 20, 30, 3'b101, 0, 3'b010, 1, 10, 1, 0, 0, 0));
    tbl.push_back(mk(3'b111, 10, 20, 30, 3'b101, 0, 3'b100, 1, 20, 0, 0, 0, 0));
    tbl.push_back(mk(3'b111, 10, 20, 30, 3'b101, 0, 3'b001, 1, 30, 1, 0, 0, 0));
    tbl.push_back(mk(3'b111, 10, 20, 30, 3'b101, 0, 3'b010, 1, 10, 1, 0, 0, 0));
    tbl.push_back(mk(3'b111, 10, 20, 30, 3'b101, 0, 3'b100, 1, 20, 0, 0, 0, 0));
    tbl.push_back(mk(3'b000, 10, 20, 30, 3'b101, 0, 3'b000, 1, 30, 1, 0, 0, 0));
    // Fill only, addr 0..3, back-to-back
    tbl.push_back(mk(3'b001,  0,  0,  0, 3'b001, 0, 3'b001, 0, 30, 1, 0, 0, 0));
    tbl.push_back(mk(3'b001,  1,  0,  0, 3'b001, 0, 3'b001, 1,  0, 1, 0, 0, 0));
    tbl.push_back(mk(3'b001,  2,  0,  0, 3'b001, 0, 3'b001, 1,  1, 1, 0, 0, 0));
    tbl.push_back(mk(3'b001,  3,  0,  0, 3'b001, 0, 3'b001, 1,  2, 1, 0, 0, 0));
    tbl.push_back(mk(3'b000,  3,  0,  0, 3'b001, 0, 3'b000, 1,  3, 1, 0, 0, 0));
    tbl.push_back(mk(3'b000,  3,  0,  0, 3'b001, 0, 3'b000, 0,  3, 1, 0, 0, 0));
    // Swap during line traffic; redundant swap_req during ACK
    tbl.push_back(mk(3'b010,  0, 100, 0, 3'b010, 1, 3'b000, 0,  3, 1, 0, 0, 0));
    tbl.push_back(mk(3'b010,  0, 100, 0, 3'b010, 0, 3'b000, 0,  3, 1, 1, 0, 0));
    tbl.push_back(mk(3'b010,  0, 100, 0, 3'b010, 1, 3'b000, 0,  3, 1, 0, 1, 0));
    tbl.push_back(mk(3'b010,  0, 100, 0, 3'b010, 0, 3'b010, 0,  3, 1, 0, 0, 0));
    tbl.push_back(mk(3'b000,  0, 100, 0, 3'b010, 0, 3'b000, 1, 100, 1, 0, 0, 0));
    tbl.push_back(mk(3'b000,  0, 100, 0, 3'b010, 0, 3'b000, 0, 100, 1, 0, 0, 0));
    // Out-of-range symbol write, sticky across a swap, then last legal pixel
    tbl.push_back(mk(3'b100,  0, 0, 307200, 3'b100, 0, 3'b100, 0, 100, 1, 0, 0, 0));
    tbl.push_back(mk(3'b000,  0, 0, 307200, 3'b100, 0, 3'b000, 0, 100, 1, 0, 0, 1));
    tbl.push_back(mk(3'b000,  0, 0, 307200, 3'b100, 1, 3'b000, 0, 100, 1, 0, 0, 1));
    tbl.push_back(mk(3'b000,  0, 0, 307200, 3'b100, 0, 3'b000, 0, 100, 1, 1, 0, 1));
    tbl.push_back(mk(3'b000,  0, 0, 307200, 3'b100, 0, 3'b000, 0, 100, 1, 0, 1, 1));
    tbl.push_back(mk(3'b000,  0, 0, 307200, 3'b100, 0, 3'b000, 0, 100, 1, 0, 0, 1));
    tbl.push_back(mk(3'b100,  0, 0, 307199, 3'b100, 0, 3'b100, 0, 100, 1, 0, 0, 1));
    tbl.push_back(mk(3'b000,  0, 0, 307199, 3'b100, 0, 3'b000, 1, 307199, 1, 0, 0, 1));

    // Reset with requests pending: nothing granted, all outputs zero
    rst_n = 1'b0;
    drive(3'b111, 10, 20, 30, 3'b111, 1'b0);
    #3;
    check_all("reset", mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    drive(3'b000, 0, 0, 0, 3'b000, 1'b0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].valid, int'(tbl[i].a0), int'(tbl[i].a1), int'(tbl[i].a2),
            tbl[i].data, tbl[i].sreq);
      #1;
      check_all($sformatf("v%0d", i), tbl[i]);
    end

    // Reset asserted while in SWAP
    @(negedge clk);
    drive(3'b000, 0, 0, 0, 3'b000, 1'b1);
    @(negedge clk);
    drive(3'b111, 10, 20, 30, 3'b101, 1'b0);
    #1;
    check("mid.swap_before", 32'(bus.swap), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all("mid.rst", mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("post.0", mk(0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #1;
    check_all("post.1", mk(0, 0, 0, 0, 0, 0, 3'b010, 1, 10, 1, 0, 0, 0));
    @(negedge clk);
    #1;
    e = mk(0, 0, 0, 0, 0, 0, 3'b100, 1, 20, 0, 0, 0, 0);
    check_all("post.2", e);
    drive(3'b000, 0, 0, 0, 3'b000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
